// File: rtl/adam_axil_ram.sv
// adam_axil_ram: single-port AXI-Lite slave SRAM.
//
// Serves single-beat word reads and byte-strobed writes, one transaction
// at a time, with the response valid the cycle after address acceptance.
// It implements the pause_req/pause_ack quiesce handshake: pause_ack high
// means nothing is in flight and no channel will be accepted.
// The storage array is not reset. Reset drops any pending response.
//
// Optional build macro:
//   ADAM_AXIL_RAM_ALIGN_CHECK_EN - accesses with nonzero byte-offset
//   address bits return SLVERR. Writes leave memory untouched, and reads
//   return zero data. Without the macro, the offset bits are ignored.
//
// The AXI-Lite slave port is flattened into axil_<channel>_<signal> ports.

module adam_axil_ram #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int SIZE       = 4096,
   parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    test,

   input  logic                    pause_req,
   output logic                    pause_ack,

   input  logic [ADDR_WIDTH-1:0]   axil_aw_addr,
   input  logic [2:0]              axil_aw_prot,
   input  logic                    axil_aw_valid,
   output logic                    axil_aw_ready,

   input  logic [DATA_WIDTH-1:0]   axil_w_data,
   input  logic [STRB_WIDTH-1:0]   axil_w_strb,
   input  logic                    axil_w_valid,
   output logic                    axil_w_ready,

   output logic [1:0]              axil_b_resp,
   output logic                    axil_b_valid,
   input  logic                    axil_b_ready,

   input  logic [ADDR_WIDTH-1:0]   axil_ar_addr,
   input  logic [2:0]              axil_ar_prot,
   input  logic                    axil_ar_valid,
   output logic                    axil_ar_ready,

   output logic [DATA_WIDTH-1:0]   axil_r_data,
   output logic [1:0]              axil_r_resp,
   output logic                    axil_r_valid,
   input  logic                    axil_r_ready
);

   localparam int MEM_AW = $clog2(SIZE);
   localparam int OFF_W  = $clog2(STRB_WIDTH);
   localparam int DEPTH  = SIZE / STRB_WIDTH;
   localparam int IDX_W  = MEM_AW - OFF_W;

   localparam logic [1:0] PAUSED     = 2'd0;
   localparam logic [1:0] IDLE       = 2'd1;
   localparam logic [1:0] WRITE_RESP = 2'd2;
   localparam logic [1:0] READ_RESP  = 2'd3;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   logic [1:0]            state;
   logic [1:0]            state_nxt;
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic                  idle_open;
   logic                  wr_acc;
   logic                  rd_acc;
   logic [IDX_W-1:0]      wr_idx;
   logic [IDX_W-1:0]      rd_idx;
   logic                  wr_in_range;
   logic                  rd_in_range;
   logic                  wr_aligned;
   logic                  rd_aligned;
   logic                  wr_ok;
   logic                  rd_ok;

   // ---------------------------------------------------------------------
   // Address decode
   // ---------------------------------------------------------------------
   assign wr_idx      = axil_aw_addr[MEM_AW-1:OFF_W];
   assign rd_idx      = axil_ar_addr[MEM_AW-1:OFF_W];

   // In range means that every address bit above the array size is zero.
   assign wr_in_range = (axil_aw_addr >> MEM_AW) == '0;
   assign rd_in_range = (axil_ar_addr >> MEM_AW) == '0;

`ifdef ADAM_AXIL_RAM_ALIGN_CHECK_EN
   assign wr_aligned  = axil_aw_addr[OFF_W-1:0] == '0;
   assign rd_aligned  = axil_ar_addr[OFF_W-1:0] == '0;
`else
   assign wr_aligned  = 1'b1;
   assign rd_aligned  = 1'b1;
`endif

   assign wr_ok = wr_in_range && wr_aligned;
   assign rd_ok = rd_in_range && rd_aligned;

   // ---------------------------------------------------------------------
   // Channel acceptance
   // ---------------------------------------------------------------------
   // Acceptance happens only in IDLE when no pause is requested.
   // A write needs both aw and w valid, so the two channels are accepted
   // together. A write wins over a read that is pending in the same cycle.
   assign idle_open     = !rst && (state == IDLE) && !pause_req;
   assign wr_acc        = idle_open && axil_aw_valid && axil_w_valid;
   assign rd_acc        = idle_open && !(axil_aw_valid && axil_w_valid)
                          && axil_ar_valid;

   assign axil_aw_ready = wr_acc;
   assign axil_w_ready  = wr_acc;
   assign axil_ar_ready = rd_acc;

   assign axil_b_valid  = (state == WRITE_RESP);
   assign axil_r_valid  = (state == READ_RESP);
   assign pause_ack     = (state == PAUSED);

   // ---------------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------------
   // Next-state logic. Pause is honoured only in IDLE, so an outstanding
   // response always completes before the block enters PAUSED.
   always_comb begin
      state_nxt = state;
      case (state)
         PAUSED: begin
            if (!pause_req) state_nxt = IDLE;
         end
         IDLE: begin
            if (pause_req)   state_nxt = PAUSED;
            else if (wr_acc) state_nxt = WRITE_RESP;
            else if (rd_acc) state_nxt = READ_RESP;
         end
         WRITE_RESP: begin
            if (axil_b_ready) state_nxt = IDLE;
         end
         READ_RESP: begin
            if (axil_r_ready) state_nxt = IDLE;
         end
         default: state_nxt = PAUSED;
      endcase
   end

   // State register. Reset parks the FSM in PAUSED and drops any response.
   always_ff @(posedge clk) begin
      if (rst) state <= PAUSED;
      else     state <= state_nxt;
   end

   // ---------------------------------------------------------------------
   // Response registers
   // ---------------------------------------------------------------------
   // These registers are captured on the accept edge. They hold stable
   // until the next accept, which cannot occur before the handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         axil_b_resp <= RESP_OKAY;
         axil_r_resp <= RESP_OKAY;
         axil_r_data <= '0;
      end else begin
         if (wr_acc) axil_b_resp <= wr_ok ? RESP_OKAY : RESP_SLVERR;
         if (rd_acc) begin
            axil_r_data <= rd_ok ? mem[rd_idx] : '0;
            axil_r_resp <= rd_ok ? RESP_OKAY : RESP_SLVERR;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Storage
   // ---------------------------------------------------------------------
   // Byte-strobed array write. This logic has no reset, so the contents
   // survive a reset. wr_acc is already gated by rst.
   always_ff @(posedge clk) begin
      if (wr_acc && wr_ok) begin
         for (int i = 0; i < STRB_WIDTH; i++) begin
            if (axil_w_strb[i]) mem[wr_idx][i*8 +: 8] <= axil_w_data[i*8 +: 8];
         end
      end
   end

   // The DFT mode, the prot fields and the offset bits in the default build
   // have no function here.
   logic unused_ok;
   assign unused_ok = ^{test, axil_aw_prot, axil_ar_prot,
                        axil_aw_addr[OFF_W-1:0], axil_ar_addr[OFF_W-1:0]};

   // ---------------------------------------------------------------------
   // Protocol properties
   // ---------------------------------------------------------------------
   // pause_ack never falls while pause_req is held.
   a_ack_hold: assert property (@(posedge clk) disable iff (rst)
      (pause_ack && pause_req) |=> pause_ack);

   // pause_ack never rises while pause_req is low.
   a_ack_low: assert property (@(posedge clk) disable iff (rst)
      (!pause_ack && !pause_req) |=> !pause_ack);

   // No channel is accepted while the block reports itself quiesced.
   a_paused_quiet: assert property (@(posedge clk) disable iff (rst)
      pause_ack |-> !(axil_aw_ready || axil_w_ready || axil_ar_ready));

   // The write response stays stable while it is stalled.
   a_b_stable: assert property (@(posedge clk) disable iff (rst)
      (axil_b_valid && !axil_b_ready) |=> (axil_b_valid && $stable(axil_b_resp)));

   // The read response stays stable while it is stalled.
   a_r_stable: assert property (@(posedge clk) disable iff (rst)
      (axil_r_valid && !axil_r_ready) |=>
         (axil_r_valid && $stable(axil_r_data) && $stable(axil_r_resp)));

endmodule

// File: tb/tb_adam_axil_ram.sv
// Testbench for adam_axil_ram.
// The stimulus process pushes the expected responses into queues. A monitor
// pops an entry and compares it on every b/r handshake. Inline checks cover
// the pause, priority, latency and stability behaviour.
module tb_adam_axil_ram;

   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;

   logic        clk = 1'b0;
   logic        rst, test, pause_req, pause_ack;
   logic [31:0] aw_addr;  logic [2:0] aw_prot; logic aw_valid, aw_ready;
   logic [31:0] w_data;   logic [3:0] w_strb;  logic w_valid, w_ready;
   logic [1:0]  b_resp;   logic b_valid, b_ready;
   logic [31:0] ar_addr;  logic [2:0] ar_prot; logic ar_valid, ar_ready;
   logic [31:0] r_data;   logic [1:0] r_resp;  logic r_valid, r_ready;

   typedef struct packed {
      logic [31:0] data;
      logic [1:0]  resp;
   } r_exp_t;

   logic [1:0] exp_b_q[$];
   r_exp_t     exp_r_q[$];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   adam_axil_ram dut (
      .clk(clk), .rst(rst), .test(test),
      .pause_req(pause_req), .pause_ack(pause_ack),
      .axil_aw_addr(aw_addr), .axil_aw_prot(aw_prot),
      .axil_aw_valid(aw_valid), .axil_aw_ready(aw_ready),
      .axil_w_data(w_data), .axil_w_strb(w_strb),
      .axil_w_valid(w_valid), .axil_w_ready(w_ready),
      .axil_b_resp(b_resp), .axil_b_valid(b_valid), .axil_b_ready(b_ready),
      .axil_ar_addr(ar_addr), .axil_ar_prot(ar_prot),
      .axil_ar_valid(ar_valid), .axil_ar_ready(ar_ready),
      .axil_r_data(r_data), .axil_r_resp(r_resp),
      .axil_r_valid(r_valid), .axil_r_ready(r_ready)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      failures++;
      $display("FAIL %s timeout", name);
   endtask

   // Scoreboard monitor that compares every response handshake.
   always @(negedge clk) begin
      if (!rst && b_valid && b_ready) begin
         if (exp_b_q.size() == 0) timeout("b_unexpected");
         else check("b_resp", 32'(b_resp), 32'(exp_b_q.pop_front()));
      end
      if (!rst && r_valid && r_ready) begin
         if (exp_r_q.size() == 0) timeout("r_unexpected");
         else begin
            r_exp_t e;
            e = exp_r_q.pop_front();
            check("r_data", r_data, e.data);
            check("r_resp", 32'(r_resp), 32'(e.resp));
         end
      end
   end

   task automatic drain();
      for (int i = 0; i < 50; i++) begin
         if (exp_b_q.size() == 0 && exp_r_q.size() == 0) return;
         @(posedge clk); #1;
      end
      timeout("drain");
   endtask

   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [1:0] resp);
      bit ok = 0;
      aw_addr = addr; w_data = data; w_strb = strb;
      aw_valid = 1; w_valid = 1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (aw_ready && w_ready) begin ok = 1; break; end
      end
      if (!ok) timeout("aw_accept");
      else exp_b_q.push_back(resp);
      @(posedge clk); #1;
      aw_valid = 0; w_valid = 0;
      drain();
   endtask

   task automatic axi_read(input logic [31:0] addr, input logic [31:0] data,
                           input logic [1:0] resp);
      bit ok = 0;
      r_exp_t e;
      ar_addr = addr; ar_valid = 1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (ar_ready) begin ok = 1; break; end
      end
      if (!ok) timeout("ar_accept");
      else begin
         check("r_valid_pre", 32'(r_valid), 32'd0);
         e.data = data; e.resp = resp;
         exp_r_q.push_back(e);
      end
      @(posedge clk); #1;
      ar_valid = 0;
      @(negedge clk);
      if (ok) check("r_latency", 32'(r_valid), 32'd1);
      drain();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      r_exp_t e;
      rst = 1; test = 0; pause_req = 1;
      aw_addr = 0; aw_prot = 0; aw_valid = 0;
      w_data = 0; w_strb = 0; w_valid = 0; b_ready = 1;
      ar_addr = 0; ar_prot = 0; ar_valid = 0; r_ready = 1;

      // Check the reset state.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_pause_ack", 32'(pause_ack), 32'd1);
      check("rst_b_valid",   32'(b_valid),   32'd0);
      check("rst_r_valid",   32'(r_valid),   32'd0);
      check("rst_r_data",    r_data,         32'd0);
      check("rst_b_resp",    32'(b_resp),    32'd0);
      check("rst_r_resp",    32'(r_resp),    32'd0);

      // While paused, pending valids must not be accepted.
      @(posedge clk); #1;
      rst = 0; aw_valid = 1; w_valid = 1; ar_valid = 1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("paused_aw_ready", 32'(aw_ready), 32'd0);
         check("paused_ar_ready", 32'(ar_ready), 32'd0);
         check("paused_ack",      32'(pause_ack), 32'd1);
      end
      @(posedge clk); #1;
      aw_valid = 0; w_valid = 0; ar_valid = 0; pause_req = 0;
      @(negedge clk);
      check("ack_until_edge", 32'(pause_ack), 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      check("ack_dropped", 32'(pause_ack), 32'd0);
      @(posedge clk); #1;

      // Byte-strobe merge.
      axi_write(32'h0, 32'h11223344, 4'hF, OKAY);
      axi_write(32'h10, 32'hDEADBEEF, 4'hF, OKAY);
      axi_write(32'h10, 32'h000000AA, 4'b0001, OKAY);
      axi_read (32'h10, 32'hDEADBEAA, OKAY);
      axi_write(32'h24, 32'hFFFFFFFF, 4'hF, OKAY);
      axi_write(32'h24, 32'h12345678, 4'b0110, OKAY);
      axi_read (32'h24, 32'hFF3456FF, OKAY);

      // Address range boundaries.
      axi_write(32'hFFC, 32'hA5A5A5A5, 4'hF, OKAY);
      axi_read (32'hFFC, 32'hA5A5A5A5, OKAY);
      axi_write(32'h1000, 32'hFFFFFFFF, 4'hF, SLVERR);
      axi_read (32'h1000, 32'h0, SLVERR);
      axi_read (32'h0, 32'h11223344, OKAY);

      // Simultaneous write and read: the write goes first. b is stalled.
      b_ready = 0;
      aw_addr = 32'h20; w_data = 32'hCAFEF00D; w_strb = 4'hF; ar_addr = 32'h20;
      aw_valid = 1; w_valid = 1; ar_valid = 1;
      @(negedge clk);
      check("prio_aw_ready", 32'(aw_ready), 32'd1);
      check("prio_ar_ready", 32'(ar_ready), 32'd0);
      exp_b_q.push_back(OKAY);
      e.data = 32'hCAFEF00D; e.resp = OKAY;
      exp_r_q.push_back(e);
      @(posedge clk); #1;
      aw_valid = 0; w_valid = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bstall_valid", 32'(b_valid), 32'd1);
         check("bstall_resp",  32'(b_resp),  32'(OKAY));
         check("bstall_ar_ready", 32'(ar_ready), 32'd0);
         @(posedge clk); #1;
      end
      b_ready = 1;
      @(negedge clk);
      check("bhs_ar_ready", 32'(ar_ready), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check("after_b_ar_ready", 32'(ar_ready), 32'd1);
      @(posedge clk); #1;
      ar_valid = 0;
      drain();

      // Pause requested during READ_RESP with r stalled.
      r_ready = 0;
      ar_addr = 32'h20; ar_valid = 1;
      @(negedge clk);
      check("pr_ar_ready", 32'(ar_ready), 32'd1);
      e.data = 32'hCAFEF00D; e.resp = OKAY;
      exp_r_q.push_back(e);
      @(posedge clk); #1;
      ar_addr = 32'h0; pause_req = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("pr_ack_low",   32'(pause_ack), 32'd0);
         check("pr_r_valid",   32'(r_valid),   32'd1);
         check("pr_r_data",    r_data,         32'hCAFEF00D);
         check("pr_ar_blocked", 32'(ar_ready), 32'd0);
         @(posedge clk); #1;
      end
      r_ready = 1;
      @(negedge clk);
      check("pr_hs_ack", 32'(pause_ack), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check("pr_idle_ack",   32'(pause_ack), 32'd0);
      check("pr_idle_ar",    32'(ar_ready),  32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check("pr_paused_ack", 32'(pause_ack), 32'd1);
      check("pr_paused_ar",  32'(ar_ready),  32'd0);
      @(posedge clk); #1;
      ar_valid = 0; pause_req = 0;
      @(posedge clk); #1;

      // Misaligned accesses.
`ifdef ADAM_AXIL_RAM_ALIGN_CHECK_EN
      axi_read (32'h12, 32'h0, SLVERR);
      axi_write(32'h13, 32'h55000000, 4'b1000, SLVERR);
      axi_read (32'h10, 32'hDEADBEAA, OKAY);
`else
      axi_read (32'h12, 32'hDEADBEAA, OKAY);
      axi_write(32'h13, 32'h55000000, 4'b1000, OKAY);
      axi_read (32'h10, 32'h55ADBEAA, OKAY);
`endif

      repeat (3) @(posedge clk);
      check("queues_empty", 32'(exp_b_q.size() + exp_r_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
